// File: rtl/valid_pipe_sink_fifo_if.sv
// Bundle of the issue-credit, pipeline-result and downstream ready/valid signals
// that surround the sink FIFO at the end of a valid-only pipeline.
interface valid_pipe_sink_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             issue_valid;
  logic             issue_ready;
  logic [WIDTH-1:0] pipe_data;
  logic             pipe_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             protocol_err;

  modport master (
    output issue_valid, pipe_data, pipe_valid, out_ready,
    input  issue_ready, out_data, out_valid, count, overflow, protocol_err
  );

  modport slave (
    input  issue_valid, pipe_data, pipe_valid, out_ready,
    output issue_ready, out_data, out_valid, count, overflow, protocol_err
  );
endinterface

// File: rtl/valid_pipe_sink_fifo.sv
// Show-ahead FIFO terminating a no-backpressure pipeline, with a credit counter
// that keeps the issuer from launching more work than the FIFO can hold.
module valid_pipe_sink_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  valid_pipe_sink_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    credits_q, credits_d;
  logic             overflow_q, overflow_d;
  logic             perr_q, perr_d;
  logic             issue_ready_s;
  logic             push_s, pop_s, issue_s, full_s;

  assign issue_ready_s = (credits_q != '0) && rst;

  // Next-state computation for pointers, occupancy, credits and sticky flags.
  always_comb begin
    pop_s      = (count_q != '0) && bus.out_ready;
    full_s     = (count_q == CW'(DEPTH));
    push_s     = bus.pipe_valid && (!full_s || pop_s);
    issue_s    = bus.issue_valid && issue_ready_s;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    credits_d  = credits_q;
    overflow_d = overflow_q | (bus.pipe_valid && full_s && !pop_s);
    perr_d     = perr_q | (bus.issue_valid && !issue_ready_s);

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Beats that arrive without a matching issue can pop more than was issued; clamp.
    case ({issue_s, pop_s})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01: begin
        if (credits_q != CW'(DEPTH)) begin
          credits_d = credits_q + CW'(1);
        end else begin
          credits_d = credits_q;
        end
      end
      default: credits_d = credits_q;
    endcase
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credits_q  <= CW'(DEPTH);
      overflow_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credits_q  <= credits_d;
      overflow_q <= overflow_d;
      perr_q     <= perr_d;
    end
  end

  // Storage array; contents are meaningless until written, so it is not reset.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_q[wr_ptr_q] <= bus.pipe_data;
    end
  end

  assign bus.issue_ready  = issue_ready_s;
  assign bus.out_data     = mem_q[rd_ptr_q];
  assign bus.out_valid    = (count_q != '0);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.protocol_err = perr_q;
endmodule

// File: tb/tb_valid_pipe_sink_fifo.sv
// Self-checking bench: a reset/fill/drain vector table, hand sequences for the
// corner cases, and a queue scoreboard that tracks every accepted beat.
module tb_valid_pipe_sink_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  valid_pipe_sink_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  valid_pipe_sink_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit          r;
    bit          iv;
    bit          pv;
    logic [31:0] pd;
    bit          ordy;
    int          exp_count;
    bit          exp_ir;
    bit          exp_ov;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        tbl[14];
  logic [31:0] sb[$];
  int          m_credits;
  bit          m_ovf, m_perr;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Compare all outputs against the scoreboard state for the current cycle.
  task automatic model_check();
    check("count", 32'(bus.count), 32'(sb.size()));
    check("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) check("out_data", bus.out_data, sb[0]);
    check("issue_ready", 32'(bus.issue_ready), 32'(rst && (m_credits != 0)));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("protocol_err", 32'(bus.protocol_err), 32'(m_perr));
  endtask

  task automatic drive(input bit r, input bit iv, input bit pv, input logic [31:0] pd, input bit ordy);
    rst = r;
    bus.issue_valid = iv;
    bus.pipe_valid = pv;
    bus.pipe_data = pd;
    bus.out_ready = ordy;
    #1;
    model_check();
  endtask

  // Apply the driven inputs to the scoreboard, then move to the next cycle.
  task automatic advance();
    bit ir, pop, full;
    if (!rst) begin
      sb.delete();
      m_credits = DEPTH;
      m_ovf = 1'b0;
      m_perr = 1'b0;
    end else begin
      ir   = (m_credits != 0);
      pop  = (sb.size() != 0) && bus.out_ready;
      full = (sb.size() == DEPTH);
      if (bus.issue_valid && !ir) m_perr = 1'b1;
      if (pop) void'(sb.pop_front());
      if (bus.pipe_valid) begin
        if (!full || pop) sb.push_back(bus.pipe_data);
        else m_ovf = 1'b1;
      end
      if (bus.issue_valid && ir && !pop) m_credits--;
      else if (pop && !(bus.issue_valid && ir) && m_credits < DEPTH) m_credits++;
    end
    @(negedge clk);
  endtask

  task automatic step(input bit r, input bit iv, input bit pv, input logic [31:0] pd, input bit ordy);
    drive(r, iv, pv, pd, ordy);
    advance();
  endtask

  initial begin
    logic [31:0] exp_t3 [4];
    bus.issue_valid = 1'b0;
    bus.pipe_valid  = 1'b1;
    bus.pipe_data   = 32'h99;
    bus.out_ready   = 1'b0;
    sb.delete();
    m_credits = DEPTH;
    m_ovf = 1'b0;
    m_perr = 1'b0;

    //            r     iv    pv    pd      ordy  cnt ir    ov    data
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h99, 1'b0, 0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h99, 1'b0, 0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h99, 1'b0, 0, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 0, 1'b1, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h1,  1'b0, 0, 1'b1, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h2,  1'b0, 1, 1'b1, 1'b1, 32'h1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 32'h3,  1'b0, 2, 1'b1, 1'b1, 32'h1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h4,  1'b0, 3, 1'b0, 1'b1, 32'h1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 4, 1'b0, 1'b1, 32'h1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 4, 1'b0, 1'b1, 32'h1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 3, 1'b1, 1'b1, 32'h2};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 2, 1'b1, 1'b1, 32'h3};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1, 1'b1, 1'b1, 32'h4};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 0, 1'b1, 1'b0, 32'h0};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].r, tbl[i].iv, tbl[i].pv, tbl[i].pd, tbl[i].ordy);
      check($sformatf("tbl%0d_count", i), 32'(bus.count), 32'(tbl[i].exp_count));
      check($sformatf("tbl%0d_issue_ready", i), 32'(bus.issue_ready), 32'(tbl[i].exp_ir));
      check($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) check($sformatf("tbl%0d_out_data", i), bus.out_data, tbl[i].exp_data);
      advance();
    end

    // Simultaneous issue/pop at one credit, then push/pop while full.
    step(1'b1, 1'b1, 1'b1, 32'h10, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h11, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h12, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("t3_credits_before", 32'(dut.credits_q), 32'd1);
    advance();
    drive(1'b1, 1'b0, 1'b1, 32'h13, 1'b0);
    check("t3_credits_hold", 32'(dut.credits_q), 32'd1);
    advance();
    step(1'b1, 1'b0, 1'b1, 32'h14, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h55, 1'b1);
    check("t3_full_before", 32'(bus.count), 32'd4);
    advance();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("t3_count_hold", 32'(bus.count), 32'd4);
    advance();
    exp_t3 = '{32'h12, 32'h13, 32'h14, 32'h55};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check($sformatf("t3_order%0d", i), bus.out_data, exp_t3[i]);
      advance();
    end

    // Overflow: a beat into a full FIFO is dropped and the flag sticks.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 32'h21 + 32'(i), 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hDEAD, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("t4_overflow_set", 32'(bus.overflow), 32'd1);
    check("t4_count_full", 32'(bus.count), 32'd4);
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check($sformatf("t4_drain%0d", i), bus.out_data, 32'h21 + 32'(i));
      advance();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("t4_empty_after", 32'(bus.out_valid), 32'd0);
    check("t4_overflow_sticky", 32'(bus.overflow), 32'd1);
    advance();

    // Protocol error: issue with no credits.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("t5_no_credit", 32'(bus.issue_ready), 32'd0);
    advance();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("t5_protocol_err", 32'(bus.protocol_err), 32'd1);
    check("t5_credits_zero", 32'(dut.credits_q), 32'd0);
    advance();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 32'h31 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Streaming wrap-around, then reset mid-stream.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'hA0 + 32'(i), 1'b1);
      if (i > 0) begin
        check($sformatf("t6_stream%0d", i - 1), bus.out_data, 32'hA0 + 32'(i - 1));
        check($sformatf("t6_count%0d", i - 1), 32'(bus.count), 32'd1);
      end
      advance();
    end
    drive(1'b1, 1'b1, 1'b1, 32'hAA, 1'b1);
    check("t6_stream9", bus.out_data, 32'hA9);
    advance();
    drive(1'b0, 1'b1, 1'b1, 32'hAB, 1'b1);
    check("t6_ready_in_reset", 32'(bus.issue_ready), 32'd0);
    advance();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_credits", 32'(dut.credits_q), 32'd4);
    check("t6_rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    advance();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/valid_pipe_sink_fifo.md
# valid_pipe_sink_fifo

Receive-side terminator for the team's valid-only generated pipelines, which have no backpressure: data and valid flow one stage per cycle. The block sits at the pipeline output and buffers each `output_valid`/`out` beat in a small FIFO. It re-presents the beats downstream on a ready/valid handshake. It also gives the upstream issuer a credit-based `issue_ready`, so the pipeline is never fed more work than the FIFO can absorb, whatever the pipeline latency.

## Interface
Parameters:
- `WIDTH`, 32, data width of pipeline result and FIFO entries.
- `DEPTH`, 4, FIFO entries and initial credit count. Power of two, ≥ 2.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-low reset: sampled on `clk`, state cleared when `rst==0`.
- `issue_valid`  input  1  upstream is presenting work to the pipeline's `input_valid` this cycle.
- `issue_ready`  output  1  a credit is available; an issue is accepted only when `issue_valid && issue_ready`.
- `pipe_data`  input  WIDTH  pipeline result (`out`).
- `pipe_valid`  input  1  pipeline result valid (`output_valid`).
- `out_data`  output  WIDTH  head-of-FIFO data.
- `out_valid`  output  1  FIFO non-empty.
- `out_ready`  input  1  downstream accepts head this cycle.
- `count`  output  $clog2(DEPTH+1)  current FIFO occupancy.
- `overflow`  output  1  sticky: a `pipe_valid` beat arrived while the FIFO was full and was dropped.
- `protocol_err`  output  1  sticky: `issue_valid` was asserted while `issue_ready==0`.

## Operation
- **Credit counter `credits`** ($clog2(DEPTH+1) bits), reset value `DEPTH`.
  - Decrements on issue (`issue_valid && issue_ready`).
  - Increments on pop (`out_valid && out_ready`).
  - Issue and pop in the same cycle leave it unchanged.
  - It never exceeds `DEPTH` and never goes below 0.
- **`issue_ready`** = `(credits != 0) && rst`. It is combinational from registered state and forced low while reset is asserted.
- **Push:** `pipe_valid==1` writes `pipe_data` to `mem[wr_ptr]`, advances `wr_ptr`, and increments `count`, unless the FIFO is full.
- **Pop:** `out_valid && out_ready` advances `rd_ptr` and decrements `count`.
- **Pointers:** `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap modulo `DEPTH` naturally.
- **Head data:** `out_data = mem[rd_ptr]` (show-ahead). `out_valid = (count != 0)`.
- **Push and pop in the same cycle:** both take effect and `count` is unchanged. This also holds when full: the write is accepted because the pop frees the slot.
- **Push while full without a pop:** the beat is dropped, `overflow` is set, and pointers and `count` are unchanged. This cannot happen when the issuer obeys `issue_ready`.
- **`issue_valid` while `issue_ready==0`:** sets `protocol_err`, and `credits` is unchanged.
- **Sticky flags** clear only on reset.
- **Ordering:** beats leave in strict arrival order, with no reordering and no duplication.

## Timing
- **Reset values** (`rst==0` at a rising edge): `credits=DEPTH`, `count=0`, `wr_ptr=rd_ptr=0`, `overflow=0`, `protocol_err=0`.
  - Resulting outputs: `out_valid=0` and `issue_ready=0` while `rst==0`; `issue_ready=1` in the first cycle after release.
  - `out_data` is don't-care while `out_valid==0`.
  - Reset mid-operation discards all buffered and in-flight data.
- **Latency:**
  - `pipe_valid` at edge N gives `out_valid=1` in cycle N+1.
  - No combinational path exists from `pipe_valid`/`pipe_data` to any output.
- **Credit return:** a pop at edge N makes `issue_ready` high in cycle N+1 if credits were 0.
- **Combinational inputs:**
  - `out_ready` does not combinationally affect `out_valid`.
  - `issue_valid` does not combinationally affect `issue_ready`.
- **Throughput:** one push and one pop per cycle sustained, with one issue per cycle while credits are available.

## Test plan
1. **Reset:** hold `rst=0` for 3 cycles with `pipe_valid=1` → `count=0`, `out_valid=0`, `issue_ready=0`. Release → `issue_ready=1`, `overflow=0`.
2. **Fill and drain:** with `out_ready=0`, issue 4 times and feed `pipe_data` 0x1, 0x2, 0x3, 0x4.
   - → `issue_ready=0` after the 4th issue, `count=4`.
   - Then `out_ready=1` → `out_data` 0x1, 0x2, 0x3, 0x4 on consecutive cycles, and `issue_ready=1` the cycle after the first pop.
3. **Simultaneous events:** at `credits=1`, issue and pop in the same cycle → `credits` stays 1.
   - With `count=4`, push 0x55 and pop in the same cycle → `count=4`, 0x55 ends up last in order.
4. **Overflow:** `count=4`, `out_ready=0`, `pipe_valid=1` with 0xDEAD → the beat is dropped, `overflow=1` and it stays set until reset. A later drain yields only the original 4 words.
5. **Protocol error:** `issue_valid=1` with `credits=0` → `protocol_err=1`, and `credits` is still 0 the next cycle.
6. **Wrap-around:** stream 10 words 0xA0–0xA9 with `out_ready=1` continuously → output 0xA0–0xA9 in order, each exactly one cycle after its push, with pointers wrapping twice. Then assert reset mid-stream → `out_valid=0` and `credits=4` the next cycle.
